// File: rtl/histogram_readout.sv
// histogram_readout: sweeps the bin memory from bin 0 to the last bin and
// streams each count with its running cumulative sum over valid/ready.
// It can zero each bin after reading it, ready for the next frame.
// Reads are throttled so that buffered beats plus reads in flight never
// exceed the 2-entry output FIFO, so backpressure never loses data.
module histogram_readout #(
  parameter int DATA_WIDTH = 14,
  parameter int ADDR_WIDTH = 8,
  parameter int SUM_WIDTH  = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear_en,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_bin,
  output logic [DATA_WIDTH-1:0] out_count,
  output logic [SUM_WIDTH-1:0]  out_cumsum,
  output logic                  out_last
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = {ADDR_WIDTH{1'b1}};

  state_t                state;
  logic                  clear_lat;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [SUM_WIDTH-1:0]  cumsum;

  logic [ADDR_WIDTH-1:0] fifo_bin   [2];
  logic [DATA_WIDTH-1:0] fifo_count [2];
  logic [SUM_WIDTH-1:0]  fifo_sum   [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_cnt;

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occ_after;
  logic [SUM_WIDTH-1:0]  next_sum;

  // Handshake, read-issue throttle and the next running sum. A read may be
  // issued when the buffer occupancy left after this cycle (including the
  // read whose data is arriving now) leaves room for its data next cycle.
  always_comb begin
    push      = inflight;
    pop       = (fifo_cnt != 2'd0) && out_ready;
    occ_after = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
    issue     = (state == RUN) && (occ_after < 3'd2);
    next_sum  = cumsum + {{(SUM_WIDTH-DATA_WIDTH){1'b0}}, mem_rd_data};
  end

  assign mem_rd_en   = issue;
  assign mem_rd_addr = rd_addr;
  assign mem_wr_en   = inflight && clear_lat;
  assign mem_wr_addr = cap_addr;
  assign mem_wr_data = '0;

  assign out_valid  = (fifo_cnt != 2'd0);
  assign out_bin    = fifo_bin[rd_ptr];
  assign out_count  = fifo_count[rd_ptr];
  assign out_cumsum = fifo_sum[rd_ptr];
  assign out_last   = out_valid && (fifo_bin[rd_ptr] == LAST_BIN);

  // Sweep sequencer, read address, capture into the output FIFO and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      clear_lat <= 1'b0;
      rd_addr   <= '0;
      inflight  <= 1'b0;
      cap_addr  <= '0;
      cumsum    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_bin[i]   <= '0;
        fifo_count[i] <= '0;
        fifo_sum[i]   <= '0;
      end
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        cap_addr <= rd_addr;
        if (rd_addr != LAST_BIN) begin
          rd_addr <= rd_addr + 1'b1;
        end
      end
      if (push) begin
        fifo_bin[wr_ptr]   <= cap_addr;
        fifo_count[wr_ptr] <= mem_rd_data;
        fifo_sum[wr_ptr]   <= next_sum;
        wr_ptr             <= ~wr_ptr;
        cumsum             <= next_sum;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};

      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            clear_lat <= clear_en;
            rd_addr   <= '0;
            cumsum    <= '0;
          end
        end
        RUN: begin
          if (issue && (rd_addr == LAST_BIN)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!inflight && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop))) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_readout.sv
// tb_histogram_readout: table-driven and directed checks of the histogram
// readout sweep, using an 8-bin instance for most scenarios and a full
// 256-bin instance for the maximum-value sweep.
module tb_histogram_readout;

  localparam int DW   = 14;
  localparam int SW   = 22;
  localparam int AW_S = 3;
  localparam int NB_S = 8;
  localparam int AW_L = 8;
  localparam int NB_L = 256;
  localparam int MAXC = 16383;

  typedef struct {
    int  fill;        // 0 keep, 1 ramp 1..8, 2 random, 3 all max
    bit  clear;
    int  mode;        // 0 always ready, 1 pattern 1,0,0,1, 2/3 random
    int  exp_total;   // -1: take from the reference model
    int  exp_cycles;  // -1: not checked
  } vec_t;

  typedef struct {
    int     bin;
    int     count;
    longint sum;
    bit     last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // small instance signals
  logic            start, clear_en, out_ready;
  logic            s_busy, s_done, s_rd_en, s_wr_en, s_valid, s_last;
  logic [AW_S-1:0] s_rd_addr, s_wr_addr, s_bin;
  logic [DW-1:0]   s_rd_data, s_wr_data, s_count;
  logic [SW-1:0]   s_sum;
  logic [DW-1:0]   mem_s [NB_S];

  // large instance signals
  logic            l_start, l_clear, l_ready;
  logic            l_busy, l_done, l_rd_en, l_wr_en, l_valid, l_last;
  logic [AW_L-1:0] l_rd_addr, l_wr_addr, l_bin;
  logic [DW-1:0]   l_rd_data, l_wr_data, l_count;
  logic [SW-1:0]   l_sum;
  logic [DW-1:0]   mem_l [NB_L];

  // scoreboard state
  int     golden [NB_S];
  beat_t  exp_q [$];
  int     wr_q [$];
  int     done_q [$];
  int     beats, last_cnt, done_cnt, max_out, issued, xfer;
  longint last_sum;
  bit     prev_stall;
  longint prev_payload;
  int     beats_l, last_cnt_l, last_bin_l;
  longint last_sum_l;

  vec_t vecs [8];

  always #5 clk = ~clk;

  // free-running cycle index
  always @(posedge clk) cyc <= cyc + 1;

  histogram_readout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW_S), .SUM_WIDTH(SW)) dut_s (
    .clk(clk), .rst(rst), .start(start), .clear_en(clear_en),
    .busy(s_busy), .done(s_done),
    .mem_rd_en(s_rd_en), .mem_rd_addr(s_rd_addr), .mem_rd_data(s_rd_data),
    .mem_wr_en(s_wr_en), .mem_wr_addr(s_wr_addr), .mem_wr_data(s_wr_data),
    .out_valid(s_valid), .out_ready(out_ready), .out_bin(s_bin),
    .out_count(s_count), .out_cumsum(s_sum), .out_last(s_last)
  );

  histogram_readout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW_L), .SUM_WIDTH(SW)) dut_l (
    .clk(clk), .rst(rst), .start(l_start), .clear_en(l_clear),
    .busy(l_busy), .done(l_done),
    .mem_rd_en(l_rd_en), .mem_rd_addr(l_rd_addr), .mem_rd_data(l_rd_data),
    .mem_wr_en(l_wr_en), .mem_wr_addr(l_wr_addr), .mem_wr_data(l_wr_data),
    .out_valid(l_valid), .out_ready(l_ready), .out_bin(l_bin),
    .out_count(l_count), .out_cumsum(l_sum), .out_last(l_last)
  );

  // bin memories: one-cycle read latency, garbage on idle read cycles
  always @(posedge clk) begin
    if (s_rd_en) s_rd_data <= mem_s[s_rd_addr];
    else         s_rd_data <= DW'($urandom);
    if (s_wr_en) mem_s[s_wr_addr] <= s_wr_data;
    if (l_rd_en) l_rd_data <= mem_l[l_rd_addr];
    else         l_rd_data <= DW'($urandom);
    if (l_wr_en) mem_l[l_wr_addr] <= l_wr_data;
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // small instance monitor: beat scoreboard, stall stability, outstanding reads, writes
  always @(negedge clk) begin : mon_s
    beat_t e;
    if (rst) begin
      prev_stall = 1'b0;
      issued = 0;
      xfer = 0;
    end else begin
      if (s_rd_en) issued++;
      if (s_wr_en) wr_q.push_back(int'(s_wr_addr));
      if (s_done) begin
        done_cnt++;
        done_q.push_back(cyc);
      end
      if (prev_stall)
        checkOutput("stall_hold", {s_valid, s_bin, s_count, s_sum, s_last}, prev_payload);
      if (s_valid && out_ready) begin
        xfer++;
        beats++;
        if (s_last) begin
          last_cnt++;
          last_sum = s_sum;
        end
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("beat_bin", s_bin, e.bin);
          checkOutput("beat_count", s_count, e.count);
          checkOutput("beat_cumsum", s_sum, e.sum);
          checkOutput("beat_last", s_last, e.last);
        end
      end
      if (issued - xfer > max_out) max_out = issued - xfer;
      prev_stall   = s_valid && !out_ready;
      prev_payload = {s_valid, s_bin, s_count, s_sum, s_last};
    end
  end

  // large instance monitor: every bin holds the maximum count
  always @(negedge clk) begin
    if (!rst && l_valid && l_ready) begin
      beats_l++;
      checkOutput("l_count", l_count, MAXC);
      checkOutput("l_cumsum", l_sum, longint'(l_bin + 1) * MAXC);
      if (l_last) begin
        last_cnt_l++;
        last_bin_l = l_bin;
        last_sum_l = l_sum;
      end
    end
  end

  function automatic logic pick_ready(input int mode, input int c);
    case (mode)
      1:       return (c % 4 == 0) || (c % 4 == 3);
      2:       return $urandom_range(0, 2) != 0;
      3:       return $urandom_range(0, 3) == 0;
      default: return 1'b1;
    endcase
  endfunction

  // reference model: beats are bins in order with a running total
  task automatic build_expected();
    longint sum = 0;
    for (int b = 0; b < NB_S; b++) begin
      sum += golden[b];
      exp_q.push_back('{b, golden[b], sum, (b == NB_S - 1)});
    end
  endtask

  task automatic reset_counters();
    wr_q.delete();
    done_q.delete();
    beats = 0;
    last_cnt = 0;
    last_sum = 0;
    done_cnt = 0;
    max_out = 0;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_busy"}, s_busy, 0);
    checkOutput({tag, "_done"}, s_done, 0);
    checkOutput({tag, "_valid"}, s_valid, 0);
    checkOutput({tag, "_last"}, s_last, 0);
    checkOutput({tag, "_rd_en"}, s_rd_en, 0);
    checkOutput({tag, "_wr_en"}, s_wr_en, 0);
    checkOutput({tag, "_bin"}, s_bin, 0);
    checkOutput({tag, "_count"}, s_count, 0);
    checkOutput({tag, "_cumsum"}, s_sum, 0);
    checkOutput({tag, "_rd_addr"}, s_rd_addr, 0);
    checkOutput({tag, "_wr_addr"}, s_wr_addr, 0);
  endtask

  // one full sweep of the small instance described by a table row
  task automatic applyStimulus(input vec_t v);
    int     c0;
    int     done_cyc = -1;
    bit     got = 1'b0;
    longint total = 0;
    case (v.fill)
      1:       for (int i = 0; i < NB_S; i++) golden[i] = i + 1;
      2:       for (int i = 0; i < NB_S; i++) golden[i] = $urandom_range(0, MAXC);
      3:       for (int i = 0; i < NB_S; i++) golden[i] = MAXC;
      default: ;
    endcase
    if (v.fill != 0)
      for (int i = 0; i < NB_S; i++) mem_s[i] = DW'(golden[i]);
    for (int i = 0; i < NB_S; i++) total += golden[i];
    exp_q.delete();
    build_expected();
    reset_counters();
    @(posedge clk); #1;
    start = 1'b1;
    clear_en = v.clear;
    out_ready = pick_ready(v.mode, 0);
    c0 = cyc;
    for (int c = 1; c < 300 && !got; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      clear_en = 1'b0;
      out_ready = pick_ready(v.mode, c);
      @(negedge clk);
      if (c == 1) checkOutput("busy_after_start", s_busy, 1);
      if (s_done) begin
        got = 1'b1;
        done_cyc = cyc;
        checkOutput("busy_at_done", s_busy, 0);
      end
    end
    checkOutput("done_seen", got, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (v.exp_cycles > 0) checkOutput("start_to_done", done_cyc - c0, v.exp_cycles);
    checkOutput("beat_total", beats, NB_S);
    checkOutput("last_total", last_cnt, 1);
    checkOutput("final_cumsum", last_sum, (v.exp_total >= 0) ? longint'(v.exp_total) : total);
    checkOutput("beats_missing", exp_q.size(), 0);
    checkOutput("outstanding_le_2", (max_out <= 2), 1);
    checkOutput("done_pulses", done_cnt, 1);
    checkOutput("write_total", wr_q.size(), v.clear ? NB_S : 0);
    for (int i = 0; i < wr_q.size(); i++) checkOutput("write_addr", wr_q[i], i);
    if (v.clear)
      for (int i = 0; i < NB_S; i++) golden[i] = 0;
    for (int i = 0; i < NB_S; i++) checkOutput("mem_after", mem_s[i], golden[i]);
  endtask

  // watchdog
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // test sequence
  initial begin : main
    int  c0;
    bit  hit;
    int  done_cyc;
    bit  got;

    vecs[0] = '{1, 1'b0, 0, 36, 11};
    vecs[1] = '{0, 1'b1, 0, 36, 11};
    vecs[2] = '{0, 1'b0, 0, 0, 11};
    vecs[3] = '{1, 1'b0, 1, 36, -1};
    vecs[4] = '{2, 1'b0, 2, -1, -1};
    vecs[5] = '{3, 1'b0, 0, 131064, 11};
    vecs[6] = '{2, 1'b1, 3, -1, -1};
    vecs[7] = '{0, 1'b0, 1, 0, -1};

    rst = 1'b1;
    start = 1'b0; clear_en = 1'b0; out_ready = 1'b0;
    l_start = 1'b0; l_clear = 1'b0; l_ready = 1'b1;
    beats_l = 0; last_cnt_l = 0; last_bin_l = 0; last_sum_l = 0;
    for (int i = 0; i < NB_S; i++) begin
      golden[i] = 0;
      mem_s[i] = '0;
    end
    for (int i = 0; i < NB_L; i++) mem_l[i] = DW'(MAXC);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // start pulses during RUN and FIN are ignored; the IDLE cycle after FIN accepts
    for (int i = 0; i < NB_S; i++) begin
      golden[i] = 10 * i + 3;
      mem_s[i] = DW'(golden[i]);
    end
    exp_q.delete();
    build_expected();
    build_expected();
    reset_counters();
    @(posedge clk); #1;
    start = 1'b1; out_ready = 1'b1;
    c0 = cyc;
    for (int c = 1; c < 40; c++) begin
      @(posedge clk); #1;
      start = (c == 3) || (c == 11) || (c == 12);
    end
    start = 1'b0;
    @(negedge clk);
    checkOutput("busy_sweep_dones", done_cnt, 2);
    checkOutput("busy_sweep_beats", beats, 2 * NB_S);
    if (done_q.size() >= 1) checkOutput("busy_done1_cycle", done_q[0] - c0, 11);
    if (done_q.size() >= 2) checkOutput("busy_done2_cycle", done_q[1] - c0, 23);
    checkOutput("busy_sweep_idle", s_busy, 0);

    // reset mid-sweep with clearing enabled, just as bin 3 has been read
    for (int i = 0; i < NB_S; i++) begin
      golden[i] = i + 1;
      mem_s[i] = DW'(golden[i]);
    end
    exp_q.delete();
    build_expected();
    reset_counters();
    @(posedge clk); #1;
    start = 1'b1; clear_en = 1'b1; out_ready = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(posedge clk); #1;
      start = 1'b0; clear_en = 1'b0;
      @(negedge clk);
      if (s_rd_en && s_rd_addr == 3'd3) hit = 1'b1;
    end
    checkOutput("abort_read3_seen", hit, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("abort");
    exp_q.delete();
    repeat (15) @(posedge clk);
    @(negedge clk);
    checkOutput("abort_no_done", done_cnt, 0);
    for (int i = 0; i < NB_S; i++) begin
      golden[i] = (i < 4) ? 0 : i + 1;
      checkOutput("abort_mem", mem_s[i], golden[i]);
    end
    applyStimulus('{0, 1'b0, 0, 26, 11});

    // full-size instance, every bin at the maximum count
    @(posedge clk); #1 l_start = 1'b1;
    c0 = cyc;
    got = 1'b0;
    done_cyc = -1;
    for (int c = 1; c < 400 && !got; c++) begin
      @(posedge clk); #1 l_start = 1'b0;
      @(negedge clk);
      if (l_done) begin
        got = 1'b1;
        done_cyc = cyc;
      end
    end
    checkOutput("l_done_seen", got, 1);
    checkOutput("l_start_to_done", done_cyc - c0, NB_L + 3);
    checkOutput("l_beat_total", beats_l, NB_L);
    checkOutput("l_last_total", last_cnt_l, 1);
    checkOutput("l_last_bin", last_bin_l, NB_L - 1);
    checkOutput("l_final_cumsum", last_sum_l, 4194048);
    checkOutput("l_mem_first", mem_l[0], MAXC);
    checkOutput("l_mem_last", mem_l[NB_L-1], MAXC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
